// File: rtl/alu_exec_stage.sv
// ALU execute stage: decodes and evaluates one operation per accepted handshake
// and holds results in a two-entry FIFO feeding the downstream stage.
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [15:0]      err_count
);

  localparam int DEPTH = 2;

  // Handshake: a transfer happens on a rising edge where valid && ready on the
  // same side; valid never depends on ready, and in_ready depends only on count.
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] alu_res;
  logic             alu_illegal;

  logic [WIDTH-1:0] buf_result  [DEPTH];
  logic             buf_zero    [DEPTH];
  logic             buf_illegal [DEPTH];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (alu_ctrl)
      3'b000:  alu_res = src_a + src_b;
      3'b001:  alu_res = src_a - src_b;
      3'b010:  alu_res = src_a & src_b;
      3'b011:  alu_res = src_a | src_b;
      3'b101:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_illegal = 1'b1;
    endcase
  end

  assign in_ready  = (count < 2'(DEPTH));
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      err_count <= 16'd0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_result[i]  <= '0;
        buf_zero[i]    <= 1'b0;
        buf_illegal[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        buf_result[wr_ptr]  <= alu_res;
        buf_zero[wr_ptr]    <= (alu_res == '0);
        buf_illegal[wr_ptr] <= alu_illegal;
        wr_ptr              <= ~wr_ptr;
        if (alu_illegal && (err_count != 16'hFFFF)) begin
          err_count <= err_count + 16'd1;
        end
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Outputs are forced to zero when empty so stale slots never leak out.
  assign result  = out_valid ? buf_result[rd_ptr]  : '0;
  assign zero    = out_valid ? buf_zero[rd_ptr]    : 1'b0;
  assign illegal = out_valid ? buf_illegal[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: vector table, directed corner sequences and a
// randomized run checked every cycle against a queue-based reference model.
module tb_alu_exec_stage;

  localparam int W  = 32;
  localparam int EW = W + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    alu_ctrl;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero;
  logic          illegal;
  logic [15:0]   err_count;

  int checks   = 0;
  int failures = 0;

  alu_exec_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .err_count (err_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: entries packed as {illegal, zero, result}
  function automatic logic [EW-1:0] ref_alu(input logic [2:0] c, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    longint   ua = longint'(a);
    longint   ub = longint'(b);
    longint   sa = a[W-1] ? ua - (longint'(1) << W) : ua;
    longint   sb = b[W-1] ? ub - (longint'(1) << W) : ub;
    longint   t;
    logic [W-1:0] r;
    logic     ill;
    ill = 1'b0;
    r   = '0;
    case (c)
      3'd0: begin t = ua + ub; r = t[W-1:0]; end
      3'd1: begin t = ua - ub; r = t[W-1:0]; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd5: r = (sa < sb) ? 1 : 0;
      default: ill = 1'b1;
    endcase
    return {ill, (r == 0), r};
  endfunction

  // scoreboard
  logic [EW-1:0] exp_q[$];
  logic [15:0]   exp_err = 16'd0;
  bit            model_valid = 1'b0;

  always @(negedge clk) begin
    logic [EW-1:0] head;
    bit acc;
    bit rel;
    if (model_valid) begin
      head = (exp_q.size() > 0) ? exp_q[0] : '0;
      check("sb_out_valid", W'(out_valid), W'(exp_q.size() > 0));
      check("sb_in_ready",  W'(in_ready),  W'(exp_q.size() < 2));
      check("sb_result",    result,        head[W-1:0]);
      check("sb_zero",      W'(zero),      W'(head[W]));
      check("sb_illegal",   W'(illegal),   W'(head[W+1]));
      check("sb_err_count", W'(err_count), W'(exp_err));
    end
    if (reset) begin
      exp_q.delete();
      exp_err     = 16'd0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      acc = in_valid && (exp_q.size() < 2);
      rel = out_ready && (exp_q.size() > 0);
      if (rel) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(ref_alu(alu_ctrl, src_a, src_b));
        if ((ref_alu(alu_ctrl, src_a, src_b) >> (W + 1)) != 0 && exp_err != 16'hFFFF)
          exp_err = exp_err + 16'd1;
      end
    end
  end

  // drivers
  task automatic set_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    alu_ctrl = c;
    src_a    = a;
    src_b    = b;
    in_valid = 1'b1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    next_cycle();
    reset    = 1'b0;
  endtask

  typedef struct {
    logic [2:0]   c;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         ill;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{3'b000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b0};
    vecs[1] = '{3'b001, 32'd5,        32'd5,        32'h0,        1'b1, 1'b0};
    vecs[2] = '{3'b101, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0};
    vecs[3] = '{3'b101, 32'h1,        32'hFFFFFFFF, 32'h0,        1'b1, 1'b0};
    vecs[4] = '{3'b010, 32'hF0F0,     32'h0FF0,     32'h00F0,     1'b0, 1'b0};
    vecs[5] = '{3'b011, 32'hF0F0,     32'h0FF0,     32'hFFF0,     1'b0, 1'b0};
    vecs[6] = '{3'b000, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0};
    vecs[7] = '{3'b001, 32'h0,        32'h1,        32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[8] = '{3'b100, 32'h12,       32'h34,       32'h0,        1'b1, 1'b1};
    vecs[9] = '{3'b111, 32'h55,       32'h55,       32'h0,        1'b1, 1'b1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctrl = 3'b000; src_a = '0; src_b = '0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_in_ready",  W'(in_ready),  1);
    check("rst_result",    result,        0);
    check("rst_zero",      W'(zero),      0);
    check("rst_illegal",   W'(illegal),   0);
    check("rst_err",       W'(err_count), 0);
    next_cycle();

    // vector table, one op at a time with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_op(vecs[i].c, vecs[i].a, vecs[i].b);
      next_cycle();
      in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i),   W'(out_valid), 1);
      check($sformatf("vec%0d_result", i),  result,        vecs[i].res);
      check($sformatf("vec%0d_zero", i),    W'(zero),      W'(vecs[i].z));
      check($sformatf("vec%0d_illegal", i), W'(illegal),   W'(vecs[i].ill));
      next_cycle();
    end

    // single illegal op after reset
    do_reset();
    set_op(3'b110, 32'hABCD, 32'h1);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check("ill_result",  result,        0);
    check("ill_illegal", W'(illegal),   1);
    check("ill_zero",    W'(zero),      1);
    check("ill_err",     W'(err_count), 1);
    next_cycle();

    // backpressure: third op waits for the first pop
    do_reset();
    out_ready = 1'b0;
    set_op(3'b000, 32'd1, 32'd2);
    next_cycle();
    set_op(3'b001, 32'd10, 32'd3);
    next_cycle();
    set_op(3'b011, 32'd8, 32'd1);
    @(negedge clk);
    check("bp_full_ready", W'(in_ready), 0);
    check("bp_head0",      result,       3);
    next_cycle();
    @(negedge clk);
    check("bp_hold_ready", W'(in_ready), 0);
    check("bp_hold_head",  result,       3);
    out_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    check("bp_head1",   result,       7);
    check("bp_ready1",  W'(in_ready), 1);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_head2",   result,        9);
    check("bp_valid2",  W'(out_valid), 1);
    next_cycle();
    @(negedge clk);
    check("bp_drained", W'(out_valid), 0);

    // streaming at count 1: one result per cycle
    next_cycle();
    set_op(3'b000, 32'd0, 32'd100);
    next_cycle();
    for (int i = 1; i <= 10; i++) begin
      set_op(3'b000, W'(i), 32'd100);
      @(negedge clk);
      check($sformatf("stream%0d_valid", i),  W'(out_valid), 1);
      check($sformatf("stream%0d_ready", i),  W'(in_ready),  1);
      check($sformatf("stream%0d_result", i), result,        W'(i - 1 + 100));
      next_cycle();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_last", result, 110);
    next_cycle();

    // reset with two entries buffered, coincident with push and pop
    do_reset();
    out_ready = 1'b0;
    set_op(3'b111, 32'd1, 32'd1);
    next_cycle();
    set_op(3'b000, 32'd4, 32'd4);
    next_cycle();
    @(negedge clk);
    check("pre_rst_ready", W'(in_ready),  0);
    check("pre_rst_err",   W'(err_count), 1);
    reset = 1'b1; out_ready = 1'b1;
    set_op(3'b000, 32'd9, 32'd9);
    next_cycle();
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst2_out_valid", W'(out_valid), 0);
    check("rst2_in_ready",  W'(in_ready),  1);
    check("rst2_err",       W'(err_count), 0);
    next_cycle();
    @(negedge clk);
    check("rst2_still_empty", W'(out_valid), 0);
    next_cycle();

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      alu_ctrl  = 3'($urandom_range(0, 7));
      src_a     = $urandom;
      src_b     = ($urandom_range(0, 5) == 0) ? src_a : $urandom;
      next_cycle();
    end
    reset = 1'b0; in_valid = 1'b0;

    // err_count saturation
    do_reset();
    out_ready = 1'b1;
    set_op(3'b110, 32'd0, 32'd0);
    repeat (65535) next_cycle();
    @(negedge clk);
    check("sat_reach", W'(err_count), 32'hFFFF);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check("sat_hold", W'(err_count), 32'hFFFF);
    next_cycle();
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Parameters
REQ-001 WIDTH, default 32, datapath width of operands and result.
REQ-002 DEPTH, fixed 2, number of result-buffer entries; not overridable.

Interface
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream presents an operation this cycle.
REQ-006 in_ready  output  1  stage can accept an operation this cycle.
REQ-007 alu_ctrl  input  3  ALU control code from the ALU decoder.
REQ-008 src_a  input  WIDTH  operand A.
REQ-009 src_b  input  WIDTH  operand B (register or immediate, already selected).
REQ-010 out_valid  output  1  buffer head holds a result.
REQ-011 out_ready  input  1  downstream consumes the head this cycle.
REQ-012 result  output  WIDTH  head result.
REQ-013 zero  output  1  head result equals 0.
REQ-014 illegal  output  1  head entry came from an unsupported alu_ctrl code.
REQ-015 err_count  output  16  saturating count of accepted illegal operations.

Function
REQ-016 Accept (push) occurs on an edge where in_valid && in_ready; consume (pop) occurs on an edge where out_valid && out_ready.
REQ-017 Operation decode: 000 add; 001 sub; 010 and; 011 or; 101 slt; all other codes (100, 110, 111, X/Z) are illegal.
REQ-018 add/sub SHALL be modulo 2^WIDTH, with no carry or overflow output.
REQ-019 slt SHALL compare src_a and src_b as two's-complement signed values and produce 1 if src_a < src_b, else 0, zero-extended to WIDTH.
REQ-020 Illegal op: result 0, illegal 1, zero 1; the entry still occupies a buffer slot and is delivered in order.
REQ-021 Result, zero, and illegal are computed from the inputs at the accept edge and stored in the buffer entry; later input changes do not affect stored entries.
REQ-022 Latency: an operation accepted at edge N is visible at the outputs (out_valid=1) in the cycle after edge N if the buffer was empty.
REQ-023 The buffer is FIFO-ordered; count ranges 0..2.
REQ-024 in_ready = (count < 2), derived from registered state only; no combinational path from out_ready to in_ready.
REQ-025 out_valid = (count > 0); result, zero, and illegal reflect the head entry and are held stable while out_valid && !out_ready.
REQ-026 Simultaneous push and pop at count 1: count stays 1, the new entry becomes head on the next cycle.
REQ-027 At count 2 with pop: count becomes 1; no push that edge because in_ready was 0.
REQ-028 At count 0, in_valid is accepted; out_ready is ignored.
REQ-029 While out_valid=0, result/zero/illegal SHALL be 0.
REQ-030 err_count increments by 1 on each accepted illegal op and saturates at 16'hFFFF with no wrap.

Reset
REQ-031 While reset=1 at an edge: count=0, buffer cleared, err_count=0; the next cycle shows out_valid=0, in_ready=1, result=0, zero=0, illegal=0.
REQ-032 A push or pop coincident with reset is discarded; reset takes priority.
REQ-033 Reset mid-operation drops all buffered entries; they are never delivered.

Verification
REQ-034 Add/sub: ctrl=000, a=32'h7FFFFFFF, b=1, out_ready=1 -> next cycle result=32'h80000000, zero=0; ctrl=001, a=5, b=5 -> result=0, zero=1.
REQ-035 slt signed: ctrl=101, a=32'hFFFFFFFF, b=1 -> result=1; a=1, b=32'hFFFFFFFF -> result=0; and/or: a=32'hF0F0, b=32'h0FF0 -> 010 gives 32'h00F0, 011 gives 32'hFFF0.
REQ-036 Backpressure: out_ready=0, push three ops back-to-back -> first two accepted, in_ready=0 on third; raise out_ready -> results emerge in order, third accepted after the first pop.
REQ-037 Simultaneous push/pop at count 1 for 10 cycles -> one result per cycle, count constant at 1, no loss or duplication.
REQ-038 Illegal: ctrl=110 accepted -> result=0, illegal=1, zero=1, err_count=1; force err_count to 16'hFFFF, then push an illegal op -> err_count stays 16'hFFFF.
REQ-039 Reset with 2 entries buffered -> next cycle out_valid=0, in_ready=1, err_count=0; the entries are never output.
